// File: rtl/operand_fetch.sv
// Operand fetch: reads two sources, bypasses writeback, blocks RAW/WAW hazards via a busy scoreboard.
// Latency: accepted instruction appears on out_* one cycle later (registered slot).
// Backpressure: in_ready drops when the slot is full and not consumed, or when a hazard is pending.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : decode handshake; in_src0/in_src1/in_dst/in_wr/in_op instruction fields
//   r0addr/r1addr         : register file read addresses (combinational from the sources)
//   r0data/r1data         : register file read data (pre-write contents)
//   wb_en/wb_addr/wb_data : writeback bus, also feeds the register file write port
//   out_valid/out_ready   : execute handshake; out_op/out_a/out_b/out_dst/out_wr registered payload
//   stall_cnt             : saturating count of cycles where decode was held off
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_src0,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              in_wr,
  input  logic [3:0]        in_op,
  output logic [ADDR_W-1:0] r0addr,
  output logic [ADDR_W-1:0] r1addr,
  input  logic [DATA_W-1:0] r0data,
  input  logic [DATA_W-1:0] r1data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_wr,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dst;
    logic              wr;
  } slot_t;

  slot_t             slot_q;
  slot_t             slot_d;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic              byp0;
  logic              byp1;
  logic              bypd;
  logic              raw0;
  logic              raw1;
  logic              waw;
  logic              hazard;
  logic              slot_free;
  logic              accept;
  logic              stalled;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign r0addr = in_src0;
  assign r1addr = in_src1;

  // A writeback landing this cycle both supplies the operand and retires
  // the pending result, so a matching source is never a hazard.
  assign byp0 = wb_en && (wb_addr == in_src0);
  assign byp1 = wb_en && (wb_addr == in_src1);
  assign bypd = wb_en && (wb_addr == in_dst);

  assign opnd_a = byp0 ? wb_data : r0data;
  assign opnd_b = byp1 ? wb_data : r1data;

  assign raw0   = busy[in_src0] && !byp0;
  assign raw1   = busy[in_src1] && !byp1;
  assign waw    = in_wr && busy[in_dst] && !bypd;
  assign hazard = raw0 || raw1 || waw;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;
  assign stalled   = in_valid && !in_ready;

  // Clear first, then set: a new writer of the register being retired
  // keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (accept && in_wr) begin
      busy_nxt[in_dst] = 1'b1;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d.op  = in_op;
      slot_d.a   = opnd_a;
      slot_d.b   = opnd_b;
      slot_d.dst = in_dst;
      slot_d.wr  = in_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      slot_q    <= '0;
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy   <= busy_nxt;
      slot_q <= slot_d;
      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (stalled && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign out_op  = slot_q.op;
  assign out_a   = slot_q.a;
  assign out_b   = slot_q.b;
  assign out_dst = slot_q.dst;
  assign out_wr  = slot_q.wr;

endmodule

// File: tb/tb_operand_fetch.sv
`timescale 1ns/1ps
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid, in_ready, in_wr, wb_en, out_valid, out_ready, out_wr;
  logic [AW-1:0] in_src0, in_src1, in_dst, r0addr, r1addr, wb_addr, out_dst;
  logic [3:0]    in_op, out_op;
  logic [DW-1:0] r0data, r1data, wb_data, out_a, out_b;
  logic [15:0]   stall_cnt;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src0(in_src0), .in_src1(in_src1), .in_dst(in_dst), .in_wr(in_wr), .in_op(in_op),
    .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_dst(out_dst), .out_wr(out_wr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, write at the clock edge.
  logic [DW-1:0] rf [8];
  assign r0data = rf[r0addr];
  assign r1data = rf[r1addr];
  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] dst;
    logic          wr;
  } exp_t;
  exp_t expq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: set of registers with results in flight, slot occupancy, stall count.
  logic [7:0]  m_busy;
  logic        m_ov;
  logic [15:0] m_stall;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = '0;
      m_ov    = 1'b0;
      m_stall = '0;
    end else begin
      logic h0, h1, hw, rdy, acc;
      exp_t e;
      h0  = m_busy[in_src0] && !(wb_en && wb_addr == in_src0);
      h1  = m_busy[in_src1] && !(wb_en && wb_addr == in_src1);
      hw  = in_wr && m_busy[in_dst] && !(wb_en && wb_addr == in_dst);
      rdy = (!m_ov || out_ready) && !(h0 || h1 || hw);
      acc = in_valid && rdy;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("busy", 64'(dut.busy), 64'(m_busy));
      chk("raddr", 64'({r0addr, r1addr}), 64'({in_src0, in_src1}));
      if (acc) begin
        e.op  = in_op;
        e.a   = (wb_en && wb_addr == in_src0) ? wb_data : rf[in_src0];
        e.b   = (wb_en && wb_addr == in_src1) ? wb_data : rf[in_src1];
        e.dst = in_dst;
        e.wr  = in_wr;
        expq.push_back(e);
      end
      if (in_valid && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (acc && in_wr) m_busy[in_dst] = 1'b1;
      m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    end
  end

  // Monitor: compares the presented slot with the oldest expected entry,
  // retiring it when execute consumes.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      expq.delete();
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got out_valid=1, expected no pending instruction (t=%0t)", $time);
      end else begin
        chk("out_a", 64'(out_a), 64'(expq[0].a));
        chk("out_b", 64'(out_b), 64'(expq[0].b));
        chk("out_op_dst_wr", 64'({out_op, out_dst, out_wr}),
            64'({expq[0].op, expq[0].dst, expq[0].wr}));
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [AW-1:0] d, input logic w, input logic [3:0] op,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ordy);
    in_valid = v; in_src0 = s0; in_src1 = s1; in_dst = d; in_wr = w; in_op = op;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    wb_en    = 1'b0;
    reset    = 1'b1;
    #2;
    reset    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    in_valid = 0; in_src0 = 0; in_src1 = 0; in_dst = 0; in_wr = 0; in_op = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    @(posedge clk);
    #1;
    // Preload register file while reset is held.
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 32'hAAAABBBB : (i == 1) ? 32'hBBBBCCCC : $urandom;
      drive(0, 0, 0, 0, 0, 0, 1, AW'(i), d, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({out_op, out_dst, out_wr}), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_busy", 64'(dut.busy), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // Basic fetch
    drive(1, 0, 1, 2, 1, 4'h5, 0, 0, 0, 1);
    chk("t1_out_a", 64'(out_a), 64'hAAAABBBB);
    chk("t1_out_b", 64'(out_b), 64'hBBBBCCCC);
    chk("t1_out_dst", 64'(out_dst), 64'd2);
    chk("t1_busy2", 64'(dut.busy[2]), 64'd1);

    // RAW stall then resolved by same-cycle writeback
    repeat (3) drive(1, 2, 1, 5, 1, 4'h6, 0, 0, 0, 1);
    chk("raw_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("raw_slot_empty", 64'(out_valid), 64'd0);
    drive(1, 2, 1, 5, 1, 4'h6, 1, 2, 32'hCCCCDDDD, 1);
    chk("raw_out_a", 64'(out_a), 64'hCCCCDDDD);
    chk("raw_out_b", 64'(out_b), 64'hBBBBCCCC);
    chk("raw_busy2", 64'(dut.busy[2]), 64'd0);
    chk("raw_busy5", 64'(dut.busy[5]), 64'd1);

    // WAW
    drive(1, 0, 0, 3, 1, 4'h7, 0, 0, 0, 1);
    drive(1, 0, 1, 3, 1, 4'h8, 0, 0, 0, 1);
    chk("waw_stall_cnt", 64'(stall_cnt), 64'd4);
    drive(1, 0, 1, 3, 1, 4'h8, 1, 3, 32'h12345678, 1);
    chk("waw_busy3", 64'(dut.busy[3]), 64'd1);
    chk("waw_out_op", 64'(out_op), 64'h8);

    // Back-pressure
    repeat (3) drive(1, 0, 1, 6, 0, 4'h9, 0, 0, 0, 0);
    chk("bp_hold_op", 64'(out_op), 64'h8);
    chk("bp_hold_a", 64'(out_a), 64'hAAAABBBB);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd7);
    drive(1, 0, 1, 6, 0, 4'h9, 0, 0, 0, 1);
    chk("bp_release_op", 64'(out_op), 64'h9);
    chk("bp_release_stall", 64'(stall_cnt), 64'd7);

    // Asynchronous reset mid-operation
    do_reset();
    drive(1, 0, 1, 2, 1, 4'h1, 0, 0, 0, 1);
    drive(1, 0, 1, 3, 1, 4'h2, 0, 0, 0, 1);
    drive(1, 0, 1, 4, 1, 4'h3, 0, 0, 0, 1);
    drive(1, 2, 0, 6, 0, 4'h4, 0, 0, 0, 0);
    chk("pre_rst_busy", 64'(dut.busy), 64'h1C);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_stall", 64'(stall_cnt), 64'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(dut.busy), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Late writeback for a dropped instruction is harmless.
    drive(0, 0, 0, 0, 0, 0, 1, 2, 32'h55AA55AA, 1);
    drive(1, 2, 2, 2, 1, 4'hA, 0, 0, 0, 1);
    chk("late_wb_a", 64'(out_a), 64'h55AA55AA);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), 4'($urandom),
            logic'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
            logic'($urandom_range(0, 3) != 0));
    end

    // Saturation
    do_reset();
    drive(1, 0, 0, 7, 1, 4'hB, 0, 0, 0, 1);
    repeat (70000) drive(1, 7, 0, 1, 0, 4'hC, 0, 0, 0, 1);
    chk("sat_cnt", 64'(stall_cnt), 64'hFFFF);
    repeat (5) drive(1, 7, 0, 1, 0, 4'hC, 0, 0, 0, 1);
    chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
